background_model_stream: RTL and testbench

- Parametrised, stream-handshaked successor of the fixed 24-bit YCbCr background model.
- Per pixel it computes:
  - a foreground mask, from the weighted absolute difference against the background;
  - a movement mask, from the luma difference against the previous frame;
  - a selectively updated background: a running average, applied only where the pixel is background.
- Adds valid/ready back-pressure, frame-synchronous control shadowing, and a warm-up (learning) mode.
- Sits between the frame-buffer readers (current/previous/background) and the background writer plus the mask outputs.

---
 rtl/background_model_stream.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_background_model_stream.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/background_model_stream.sv
// Streaming background model: foreground/movement masks and a selective running-average
// background update. Define BACKGROUND_MODEL_FG_COUNT_EN to add a per-frame foreground counter.
module background_model_stream #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned CH_WIDTH    = 8,
  parameter int unsigned ALPHA_FRAC  = 7,
  parameter int unsigned INIT_FRAMES = 2,
  localparam int unsigned PIX_W      = CHANNELS * CH_WIDTH,
  localparam int unsigned SUM_W      = CH_WIDTH + 4
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [PIX_W-1:0]    s_cur,
  input  logic [PIX_W-1:0]    s_prev,
  input  logic [PIX_W-1:0]    s_bg,
  input  logic                s_sof,
  input  logic                s_eol,
  input  logic [ALPHA_FRAC:0] alpha,
  input  logic [SUM_W-1:0]    bg_th,
  input  logic [CH_WIDTH-1:0] fd_th,
  input  logic                learn_restart,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [PIX_W-1:0]    m_bg,
  output logic [PIX_W-1:0]    m_fg_mask,
  output logic [PIX_W-1:0]    m_mv_mask,
  output logic                m_sof,
  output logic                m_eol,
  output logic                init_active
`ifdef BACKGROUND_MODEL_FG_COUNT_EN
  ,
  output logic [31:0]         fg_count,
  output logic                fg_count_valid
`endif
);

  // Luma is the most significant slice of the pixel word.
  localparam int unsigned LUMA_LSB = (CHANNELS - 1) * CH_WIDTH;
  localparam int unsigned PROD_W   = CH_WIDTH + ALPHA_FRAC + 1;
  localparam logic [ALPHA_FRAC:0] ALPHA_ONE = {1'b1, {ALPHA_FRAC{1'b0}}};

  typedef enum logic [0:0] {StLearn, StRun} learn_state_e;

  logic ce, acc, sof_acc;

  assign ce      = !m_valid | m_ready;
  assign s_ready = ce;
  assign acc     = s_valid & ce;
  assign sof_acc = acc & s_sof;

  // Only the luma of the previous frame takes part in motion detection.
  logic unused_prev;
  assign unused_prev = ^s_prev;

  // Frame-synchronous control shadows; the SOF beat itself uses the fresh values.
  logic [ALPHA_FRAC:0]  alpha_q, alpha_clamped, alpha_eff;
  logic [SUM_W-1:0]     bg_th_q, bg_th_eff;
  logic [CH_WIDTH-1:0]  fd_th_q, fd_th_eff;

  assign alpha_clamped = (alpha > ALPHA_ONE) ? ALPHA_ONE : alpha;
  assign alpha_eff     = s_sof ? alpha_clamped : alpha_q;
  assign bg_th_eff     = s_sof ? bg_th : bg_th_q;
  assign fd_th_eff     = s_sof ? fd_th : fd_th_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      alpha_q <= '0;
      bg_th_q <= '1;
      fd_th_q <= '1;
    end else if (sof_acc) begin
      alpha_q <= alpha_clamped;
      bg_th_q <= bg_th;
      fd_th_q <= fd_th;
    end
  end

  // Warm-up control
  learn_state_e state_q, state_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic         pix_init;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StLearn;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    pix_init    = (state_q == StLearn);
    if (learn_restart) begin
      state_d     = StLearn;
      frame_cnt_d = sof_acc ? 8'd1 : 8'd0;
      if (sof_acc) pix_init = 1'b1;
    end else if (sof_acc && state_q == StLearn) begin
      if (frame_cnt_q >= 8'(INIT_FRAMES)) begin
        state_d  = StRun;
        pix_init = 1'b0;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  assign init_active = (state_q == StLearn);

  // Stage 1: capture pixel, per-pixel mode and effective controls
  logic                s1_valid, s1_sof, s1_eol, s1_init;
  logic [PIX_W-1:0]    s1_cur, s1_bg;
  logic [CH_WIDTH-1:0] s1_prev_y;
  logic [ALPHA_FRAC:0] s1_alpha;
  logic [SUM_W-1:0]    s1_bg_th;
  logic [CH_WIDTH-1:0] s1_fd_th;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      s1_init   <= 1'b0;
      s1_cur    <= '0;
      s1_bg     <= '0;
      s1_prev_y <= '0;
      s1_alpha  <= '0;
      s1_bg_th  <= '0;
      s1_fd_th  <= '0;
    end else if (ce) begin
      s1_valid  <= s_valid;
      s1_sof    <= s_sof;
      s1_eol    <= s_eol;
      s1_init   <= pix_init;
      s1_cur    <= s_cur;
      s1_bg     <= s_bg;
      s1_prev_y <= s_prev[LUMA_LSB +: CH_WIDTH];
      s1_alpha  <= alpha_eff;
      s1_bg_th  <= bg_th_eff;
      s1_fd_th  <= fd_th_eff;
    end
  end

  // Stage 2: absolute differences
  logic [PIX_W-1:0]    diff_d;
  logic [CH_WIDTH-1:0] dy_d, s1_cur_y;

  assign s1_cur_y = s1_cur[LUMA_LSB +: CH_WIDTH];
  assign dy_d     = (s1_cur_y >= s1_prev_y) ? s1_cur_y - s1_prev_y : s1_prev_y - s1_cur_y;

  always_comb begin
    diff_d = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      diff_d[k*CH_WIDTH +: CH_WIDTH] =
          (s1_cur[k*CH_WIDTH +: CH_WIDTH] >= s1_bg[k*CH_WIDTH +: CH_WIDTH]) ?
          s1_cur[k*CH_WIDTH +: CH_WIDTH] - s1_bg[k*CH_WIDTH +: CH_WIDTH] :
          s1_bg[k*CH_WIDTH +: CH_WIDTH] - s1_cur[k*CH_WIDTH +: CH_WIDTH];
    end
  end

  logic                s2_valid, s2_sof, s2_eol, s2_init;
  logic [PIX_W-1:0]    s2_cur, s2_bg, s2_diff;
  logic [CH_WIDTH-1:0] s2_dy;
  logic [ALPHA_FRAC:0] s2_alpha;
  logic [SUM_W-1:0]    s2_bg_th;
  logic [CH_WIDTH-1:0] s2_fd_th;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_init  <= 1'b0;
      s2_cur   <= '0;
      s2_bg    <= '0;
      s2_diff  <= '0;
      s2_dy    <= '0;
      s2_alpha <= '0;
      s2_bg_th <= '0;
      s2_fd_th <= '0;
    end else if (ce) begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      s2_init  <= s1_init;
      s2_cur   <= s1_cur;
      s2_bg    <= s1_bg;
      s2_diff  <= diff_d;
      s2_dy    <= dy_d;
      s2_alpha <= s1_alpha;
      s2_bg_th <= s1_bg_th;
      s2_fd_th <= s1_fd_th;
    end
  end

  // Stage 3: weighted sum (chroma counts double) and threshold decisions
  logic [SUM_W-1:0] w_sum;
  logic             fg_d, mv_d;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (k == int'(CHANNELS) - 1) begin
        w_sum = w_sum + SUM_W'(s2_diff[k*CH_WIDTH +: CH_WIDTH]);
      end else begin
        w_sum = w_sum + (SUM_W'(s2_diff[k*CH_WIDTH +: CH_WIDTH]) << 1);
      end
    end
  end

  assign fg_d = (w_sum > s2_bg_th);
  assign mv_d = (s2_dy > s2_fd_th);

  logic                s3_valid, s3_sof, s3_eol, s3_init, s3_fg, s3_mv;
  logic [PIX_W-1:0]    s3_cur, s3_bg;
  logic [ALPHA_FRAC:0] s3_alpha;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s3_valid <= 1'b0;
      s3_sof   <= 1'b0;
      s3_eol   <= 1'b0;
      s3_init  <= 1'b0;
      s3_fg    <= 1'b0;
      s3_mv    <= 1'b0;
      s3_cur   <= '0;
      s3_bg    <= '0;
      s3_alpha <= '0;
    end else if (ce) begin
      s3_valid <= s2_valid;
      s3_sof   <= s2_sof;
      s3_eol   <= s2_eol;
      s3_init  <= s2_init;
      s3_fg    <= fg_d;
      s3_mv    <= mv_d;
      s3_cur   <= s2_cur;
      s3_bg    <= s2_bg;
      s3_alpha <= s2_alpha;
    end
  end

  // Stage 4: running-average blend and output registers
  logic [PROD_W-1:0] blend_sum;
  logic [PIX_W-1:0]  blend_pix;

  always_comb begin
    blend_pix = '0;
    blend_sum = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      blend_sum = PROD_W'(s3_cur[k*CH_WIDTH +: CH_WIDTH]) * PROD_W'(s3_alpha)
                + PROD_W'(s3_bg[k*CH_WIDTH +: CH_WIDTH]) * PROD_W'(ALPHA_ONE - s3_alpha);
      blend_pix[k*CH_WIDTH +: CH_WIDTH] = CH_WIDTH'(blend_sum >> ALPHA_FRAC);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid   <= 1'b0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
      m_bg      <= '0;
      m_fg_mask <= '0;
      m_mv_mask <= '0;
    end else if (ce) begin
      m_valid <= s3_valid;
      m_sof   <= s3_sof;
      m_eol   <= s3_eol;
      if (s3_init) begin
        m_bg      <= s3_cur;
        m_fg_mask <= '0;
        m_mv_mask <= '0;
      end else begin
        m_bg      <= (s3_fg | s3_mv) ? s3_bg : blend_pix;
        m_fg_mask <= {PIX_W{s3_fg}};
        m_mv_mask <= {PIX_W{s3_mv}};
      end
    end
  end

`ifdef BACKGROUND_MODEL_FG_COUNT_EN
  // Counted at the output handshake; an SOF beat closes the previous frame and opens the next.
  logic [31:0] fg_run_q;
  logic        out_beat, beat_fg;

  assign out_beat = m_valid & m_ready;
  assign beat_fg  = m_fg_mask[0];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fg_run_q       <= '0;
      fg_count       <= '0;
      fg_count_valid <= 1'b0;
    end else begin
      fg_count_valid <= 1'b0;
      if (out_beat) begin
        if (m_sof) begin
          fg_count       <= fg_run_q;
          fg_count_valid <= 1'b1;
          fg_run_q       <= {31'b0, beat_fg};
        end else if (beat_fg && fg_run_q != '1) begin
          fg_run_q <= fg_run_q + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_background_model_stream.sv
// Scoreboard bench for background_model_stream: randomized stream vs. a frame-level reference model.
module tb_background_model_stream;

  localparam int INIT = 2;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_valid = 1'b0, s_ready;
  logic [23:0] s_cur = '0, s_prev = '0, s_bg = '0;
  logic        s_sof = 1'b0, s_eol = 1'b0;
  logic [7:0]  alpha = '0;
  logic [11:0] bg_th = '0;
  logic [7:0]  fd_th = '0;
  logic        learn_restart = 1'b0;
  logic        m_valid, m_ready = 1'b1;
  logic [23:0] m_bg, m_fg_mask, m_mv_mask;
  logic        m_sof, m_eol, init_active;

  background_model_stream dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_cur         (s_cur),
    .s_prev        (s_prev),
    .s_bg          (s_bg),
    .s_sof         (s_sof),
    .s_eol         (s_eol),
    .alpha         (alpha),
    .bg_th         (bg_th),
    .fd_th         (fd_th),
    .learn_restart (learn_restart),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_bg          (m_bg),
    .m_fg_mask     (m_fg_mask),
    .m_mv_mask     (m_mv_mask),
    .m_sof         (m_sof),
    .m_eol         (m_eol),
    .init_active   (init_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] bg;
    logic [23:0] fgm;
    logic [23:0] mvm;
    logic        sof;
    logic        eol;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   run_model = 0;
  bit   lat_check = 0;
  bit   rnd_ready = 0;

  // Reference model state
  bit learning = 1;
  int frames = 0;
  int sh_alpha = 0, sh_bg = 4095, sh_fd = 255;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic exp_t model_pix(logic [23:0] cur, logic [23:0] prev, logic [23:0] bg,
                                     bit learn, int a, int bth, int fth);
    exp_t e;
    int   w, c, b;
    bit   fg, mv;
    w = 0;
    for (int k = 0; k < 3; k++) begin
      c = int'(cur[8*k +: 8]);
      b = int'(bg[8*k +: 8]);
      w += ((k == 2) ? 1 : 2) * absd(c, b);
    end
    fg = (w > bth);
    mv = (absd(int'(cur[23:16]), int'(prev[23:16])) > fth);
    e.sof = 1'b0;
    e.eol = 1'b0;
    e.cyc = 0;
    if (learn) begin
      e.bg  = cur;
      e.fgm = '0;
      e.mvm = '0;
    end else begin
      e.fgm = fg ? 24'hFFFFFF : 24'h0;
      e.mvm = mv ? 24'hFFFFFF : 24'h0;
      e.bg  = bg;
      if (!fg && !mv) begin
        for (int k = 0; k < 3; k++) begin
          c = int'(cur[8*k +: 8]);
          b = int'(bg[8*k +: 8]);
          e.bg[8*k +: 8] = 8'((a * c + (128 - a) * b) / 128);
        end
      end
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: model every accepted beat and push its expectation.
  always @(negedge clk) begin
    if (aresetn && run_model) begin
      bit   acc, pix_learn;
      exp_t e;
      check("init_active", 128'(init_active), 128'(learning));
      acc = s_valid && s_ready;
      if (acc && s_sof) begin
        sh_alpha = (alpha > 8'd128) ? 128 : int'(alpha);
        sh_bg    = int'(bg_th);
        sh_fd    = int'(fd_th);
      end
      pix_learn = learning;
      if (learn_restart) begin
        learning = 1;
        if (acc && s_sof) begin
          frames    = 1;
          pix_learn = 1;
        end else begin
          frames = 0;
        end
      end else if (acc && s_sof && learning) begin
        frames++;
        if (frames > INIT) learning = 0;
        pix_learn = learning;
      end
      if (acc) begin
        e = model_pix(s_cur, s_prev, s_bg, pix_learn, sh_alpha, sh_bg, sh_fd);
        e.sof = s_sof;
        e.eol = s_eol;
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: pop and compare on every output handshake; also watch stall stability.
  bit           stalled_prev = 0;
  logic [127:0] held;

  always @(negedge clk) begin
    if (aresetn && run_model) begin
      exp_t e;
      if (stalled_prev)
        check("stall_hold", 128'({m_valid, m_sof, m_eol, m_bg, m_fg_mask, m_mv_mask}), held);
      stalled_prev = m_valid && !m_ready;
      held = 128'({m_valid, m_sof, m_eol, m_bg, m_fg_mask, m_mv_mask});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("m_bg", 128'(m_bg), 128'(e.bg));
          check("m_fg_mask", 128'(m_fg_mask), 128'(e.fgm));
          check("m_mv_mask", 128'(m_mv_mask), 128'(e.mvm));
          check("sof_eol", 128'({m_sof, m_eol}), 128'({e.sof, e.eol}));
          if (lat_check) check("latency", 128'(cyc - e.cyc), 128'(4));
        end
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive(logic [23:0] cur, logic [23:0] prev, logic [23:0] bg,
                       bit sof, bit eol, bit restart, bit rnd);
    bit done;
    done = 0;
    s_cur = cur;
    s_prev = prev;
    s_bg = bg;
    s_sof = sof;
    s_eol = eol;
    learn_restart = restart;
    for (int t = 0; t < 1000 && !done; t++) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      done = s_valid && s_ready;
      @(posedge clk);
      #1;
      learn_restart = 1'b0;
    end
    s_valid = 1'b0;
    if (!done) begin
      $display("FAIL input_accept actual=timeout required=accepted");
      $fatal(1, "input never accepted");
    end
  endtask

  task automatic frame(logic [23:0] cur, logic [23:0] prev, logic [23:0] bg,
                       int a, int bth, int fth, int restart_at);
    alpha = 8'(a);
    bg_th = 12'(bth);
    fd_th = 8'(fth);
    for (int i = 0; i < 8; i++) drive(cur, prev, bg, i == 0, (i % 4) == 3, i == restart_at, 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", 128'(m_valid), 128'(0));
    check("reset_outputs", 128'({m_bg, m_fg_mask, m_mv_mask, m_sof, m_eol}), 128'(0));
    check("reset_init_active", 128'(init_active), 128'(1));
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    run_model = 1;
    lat_check = 1;

    // Warm-up: two learning frames, third SOF ends it
    frame(24'h404040, 24'h404040, 24'h404040, 64, 10, 5, -1);
    frame(24'h404040, 24'h404040, 24'h404040, 64, 10, 5, -1);
    check("init_after_2_frames", 128'(init_active), 128'(1));
    frame(24'h404040, 24'h404040, 24'h404040, 64, 10, 5, -1);
    check("init_after_3rd_sof", 128'(init_active), 128'(0));

    // Threshold boundary, alpha blend and clamp, movement boundary
    frame(24'h8A8080, 24'h8A8080, 24'h808080, 64, 10, 5, -1);
    frame(24'h8A8080, 24'h8A8080, 24'h808080, 64, 9, 5, -1);
    frame(24'hC88080, 24'hC88080, 24'h648080, 64, 4095, 255, -1);
    frame(24'hC88080, 24'hC88080, 24'h648080, 200, 4095, 255, -1);
    frame(24'h148080, 24'h1A8080, 24'h148080, 64, 4095, 5, -1);
    frame(24'h148080, 24'h198080, 24'h148080, 64, 4095, 5, -1);

    // Restart mid-frame: counter back to 0, three further SOFs to leave warm-up
    frame(24'h305070, 24'h305070, 24'h304070, 32, 20, 5, 3);
    frame(24'h305070, 24'h305070, 24'h304070, 32, 20, 5, -1);
    frame(24'h305070, 24'h305070, 24'h304070, 32, 20, 5, -1);
    check("init_restart_mid", 128'(init_active), 128'(1));
    frame(24'h305070, 24'h305070, 24'h304070, 32, 20, 5, -1);
    check("init_restart_mid_done", 128'(init_active), 128'(0));

    // Restart on the SOF beat: that frame counts as frame 1
    frame(24'h607080, 24'h607080, 24'h607080, 32, 20, 5, 0);
    frame(24'h607080, 24'h607080, 24'h607080, 32, 20, 5, -1);
    check("init_restart_sof", 128'(init_active), 128'(1));
    frame(24'h607080, 24'h607080, 24'h607080, 32, 20, 5, -1);
    check("init_restart_sof_done", 128'(init_active), 128'(0));
    drain();
    lat_check = 0;

    // Random traffic with back-pressure on both sides
    rnd_ready = 1;
    for (int f = 0; f < 125; f++) begin
      int rs;
      rs = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      for (int i = 0; i < 8; i++) begin
        logic [23:0] cur, bg, prev;
        cur = 24'($urandom);
        for (int k = 0; k < 3; k++) bg[8*k +: 8] = cur[8*k +: 8] ^ 8'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) bg = 24'($urandom);
        prev = cur ^ {4'h0, 4'($urandom_range(0, 15)), 16'h0};
        alpha = 8'($urandom_range(0, 255));
        bg_th = 12'($urandom_range(0, 60));
        fd_th = 8'($urandom_range(0, 20));
        drive(cur, prev, bg, i == 0, (i % 4) == 3, i == rs, 1);
      end
    end
    rnd_ready = 0;
    drain();
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
